// File: rtl/complex_mac_if.sv
// Sample-in / result-out streaming bus of the complex MAC engine.
// master = sample source plus result sink, slave = engine.
interface complex_mac_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 21
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_re;
  logic signed [ACC_W-1:0] out_im;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im
  );
endinterface

// File: rtl/complex_mac_engine.sv
// Complex MAC: latches a coefficient, accumulates LEN sample*coef products, emits one sum.
// Result valid 1 cycle after the last sample handshake; held in STOP until out_ready.
module complex_mac_engine #(
  parameter int WIDTH = 8,
  parameter int LEN   = 16,
  parameter int ACC_W = 2*WIDTH+1+$clog2(LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] coef_re,
  input  logic signed [WIDTH-1:0] coef_im,
  complex_mac_if.slave            bus,
  output logic [1:0]              state,
  output logic                    err
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STOP = 2'b10;
  localparam logic [1:0] ERR  = 2'b11;

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN-1);

  logic [1:0]              state_q;
  logic [CNT_W-1:0]        count;
  logic signed [WIDTH-1:0] c_re, c_im;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [ACC_W-1:0] out_re_q, out_im_q;

  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   prod_re, prod_im;
  logic signed [ACC_W-1:0]   add_re, add_im, sum_re, sum_im;
  logic                      ovf_re, ovf_im, hs;

  assign p_rr = bus.in_re * c_re;
  assign p_ii = bus.in_im * c_im;
  assign p_ri = bus.in_re * c_im;
  assign p_ir = bus.in_im * c_re;

  assign prod_re = {p_rr[2*WIDTH-1], p_rr} - {p_ii[2*WIDTH-1], p_ii};
  assign prod_im = {p_ri[2*WIDTH-1], p_ri} + {p_ir[2*WIDTH-1], p_ir};

  // Size casts sign-extend (or truncate when ACC_W is overridden narrow).
  assign add_re = ACC_W'(prod_re);
  assign add_im = ACC_W'(prod_im);
  assign sum_re = acc_re + add_re;
  assign sum_im = acc_im + add_im;

  assign ovf_re = (acc_re[ACC_W-1] == add_re[ACC_W-1]) && (sum_re[ACC_W-1] != acc_re[ACC_W-1]);
  assign ovf_im = (acc_im[ACC_W-1] == add_im[ACC_W-1]) && (sum_im[ACC_W-1] != acc_im[ACC_W-1]);

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == STOP);
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign hs            = bus.in_valid && bus.in_ready;
  assign state         = state_q;
  assign err           = (state_q == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count    <= '0;
      c_re     <= '0;
      c_im     <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            c_re    <= coef_re;
            c_im    <= coef_im;
            acc_re  <= '0;
            acc_im  <= '0;
            count   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A start here is a protocol violation and also drops any sample in flight.
          if (start) begin
            state_q <= ERR;
          end else if (hs) begin
            if (ovf_re || ovf_im) begin
              state_q <= ERR;
            end else begin
              acc_re <= sum_re;
              acc_im <= sum_im;
              count  <= count + 1'b1;
              if (count == LAST) begin
                out_re_q <= sum_re;
                out_im_q <= sum_im;
                state_q  <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        ERR: begin
          if (clear) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
